// File: rtl/sram_bist_if.sv
// Request/response bus between the BIST sequencer (master) and sram_ctrl (slave).
// Carries the one-cycle mem strobe, access qualifiers and both data directions.
interface sram_bist_if #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 16
);
  logic              mem;
  logic              rw;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_f2s;
  logic              ready;
  logic [DATA_W-1:0] data_s2f_r;

  modport master (
    output mem, rw, addr, data_f2s,
    input  ready, data_s2f_r
  );

  modport slave (
    input  mem, rw, addr, data_f2s,
    output ready, data_s2f_r
  );
endinterface

// File: rtl/sram_bist.sv
// SRAM self-test: writes then reads back every address with a true and then an
// inverted address-derived pattern, counting mismatches and latching the first bad address.
module sram_bist #(
  parameter int                ADDR_W    = 18,
  parameter int                DATA_W    = 16,
  parameter logic [ADDR_W-1:0] LAST_ADDR = '1,
  parameter logic [DATA_W-1:0] SEED      = 16'hA5C3
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  sram_bist_if.master       bus,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_pass,
  output logic [15:0]       o_err_count,
  output logic [ADDR_W-1:0] o_fail_addr
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WR_REQ  = 3'd1;
  localparam logic [2:0] S_WR_WAIT = 3'd2;
  localparam logic [2:0] S_RD_REQ  = 3'd3;
  localparam logic [2:0] S_RD_WAIT = 3'd4;
  localparam logic [2:0] S_FIN     = 3'd5;

  logic [2:0]        r_state;
  logic              r_phase;
  logic              r_mem;
  logic              r_rw;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic              r_busy;
  logic              r_done;
  logic              r_pass;
  logic [15:0]       r_err_count;
  logic [ADDR_W-1:0] r_fail_addr;

  logic              w_complete;
  logic              w_last;
  logic [DATA_W-1:0] w_expected;

  // Pattern: low address bits XOR seed, fully inverted in phase 1.
  function automatic logic [DATA_W-1:0] f_expected(input logic [ADDR_W-1:0] a, input logic ph);
    return DATA_W'(a) ^ SEED ^ {DATA_W{ph}};
  endfunction

  // The mem cycle itself never counts as completion, even though ready is still high then.
  assign w_complete = !r_mem && bus.ready;
  assign w_last     = (r_addr == LAST_ADDR);
  assign w_expected = f_expected(r_addr, r_phase);

  // Sequencer state, bus request registers and test status.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_phase     <= 1'b0;
      r_mem       <= 1'b0;
      r_rw        <= 1'b1;
      r_addr      <= '0;
      r_data      <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_err_count <= 16'h0000;
      r_fail_addr <= '0;
    end else begin
      r_mem <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_addr      <= '0;
            r_phase     <= 1'b0;
            r_err_count <= 16'h0000;
            r_fail_addr <= '0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= S_WR_REQ;
          end
        end
        S_WR_REQ: begin
          if (bus.ready) begin
            r_mem   <= 1'b1;
            r_rw    <= 1'b0;
            r_data  <= w_expected;
            r_state <= S_WR_WAIT;
          end
        end
        S_WR_WAIT: begin
          if (w_complete) begin
            if (w_last) begin
              r_addr  <= '0;
              r_state <= S_RD_REQ;
            end else begin
              r_addr  <= r_addr + ADDR_W'(1);
              r_state <= S_WR_REQ;
            end
          end
        end
        S_RD_REQ: begin
          if (bus.ready) begin
            r_mem   <= 1'b1;
            r_rw    <= 1'b1;
            r_state <= S_RD_WAIT;
          end
        end
        S_RD_WAIT: begin
          if (w_complete) begin
            if (bus.data_s2f_r != w_expected) begin
              if (r_err_count != 16'hFFFF) begin
                r_err_count <= r_err_count + 16'd1;
              end
              if (r_err_count == 16'h0000) begin
                r_fail_addr <= r_addr;
              end
            end
            if (!w_last) begin
              r_addr  <= r_addr + ADDR_W'(1);
              r_state <= S_RD_REQ;
            end else if (!r_phase) begin
              r_phase <= 1'b1;
              r_addr  <= '0;
              r_state <= S_WR_REQ;
            end else begin
              r_state <= S_FIN;
            end
          end
        end
        S_FIN: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_pass  <= (r_err_count == 16'h0000);
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.mem      = r_mem;
  assign bus.rw       = r_rw;
  assign bus.addr     = r_addr;
  assign bus.data_f2s = r_data;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_pass       = r_pass;
  assign o_err_count  = r_err_count;
  assign o_fail_addr  = r_fail_addr;

endmodule
